exwb_stage: RTL and testbench

Parametrised EX→WB pipeline stage carrying NUM_CH execution-unit results (ALU, forwarder, jump, branch, mem, …) to the reorder buffer. Each channel is an independent 2-entry skid buffer with a valid/ready handshake, so a stalled ROB write port back-pressures only its own unit. A global flush discards all in-flight results on mispredict. Optional per-channel stall counters support performance analysis.

---
 rtl/exwb_pkg.sv | 22 ++
 rtl/exwb_skid.sv | 86 ++++++++
 rtl/exwb_stage.sv | 50 +++++
 tb/tb_exwb_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exwb_pkg.sv
// Shared types and constants for the EX->WB result stage.
package exwb_pkg;

    localparam int TAG_W_DEF  = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic [TAG_W_DEF-1:0] TAG_INVALID = '1;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  target;
        logic [DATA_W_DEF-1:0] data;
    } exwb_entry_t;

    typedef enum logic [2:0] {
        CH_ALU,
        CH_FWD,
        CH_JUMP,
        CH_BRANCH,
        CH_MEM
    } exwb_ch_e;

endpackage

// File: rtl/exwb_skid.sv
// Single-channel 2-entry skid buffer; EXWB_PERF_CNT_EN adds a saturating stall counter.
module exwb_skid
    import exwb_pkg::*;
#(
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_target,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_target,
    output logic [DATA_W-1:0] out_data
`ifdef EXWB_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [TAG_W-1:0] TAG_NONE = '1;

    typedef struct packed {
        logic [TAG_W-1:0]  target;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t     mem [2];
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Ready depends only on stored occupancy, so out_ready never reaches in_ready.
    assign in_ready   = (count != 2'd2);
    assign out_valid  = (count != 2'd0);
    assign push       = in_valid && in_ready && !flush && (in_target != TAG_NONE);
    assign pop        = out_valid && out_ready && !flush;
    assign out_target = out_valid ? mem[head].target : TAG_NONE;
    assign out_data   = mem[head].data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= {in_target, in_data};
    end

`ifdef EXWB_PERF_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 16'd0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: rtl/exwb_stage.sv
// EX->WB stage: NUM_CH independent skid-buffered result channels toward the ROB.
// Optional per-channel stall counters are enabled with EXWB_PERF_CNT_EN.
module exwb_stage
    import exwb_pkg::*;
#(
    parameter int NUM_CH = int'(CH_MEM) + 1,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*TAG_W-1:0]  in_target,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*TAG_W-1:0]  out_target,
    output logic [NUM_CH*DATA_W-1:0] out_data
`ifdef EXWB_PERF_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]     stall_cnt
`endif
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        exwb_skid #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .in_valid   (in_valid[gi]),
            .in_ready   (in_ready[gi]),
            .in_target  (in_target[gi*TAG_W +: TAG_W]),
            .in_data    (in_data[gi*DATA_W +: DATA_W]),
            .out_valid  (out_valid[gi]),
            .out_ready  (out_ready[gi]),
            .out_target (out_target[gi*TAG_W +: TAG_W]),
            .out_data   (out_data[gi*DATA_W +: DATA_W])
`ifdef EXWB_PERF_CNT_EN
            ,
            .stall_cnt  (stall_cnt[gi*16 +: 16])
`endif
        );
    end

endmodule

// File: tb/tb_exwb_stage.sv
// Scoreboard bench for exwb_stage: per-channel FIFO model, directed scenarios and random traffic.
module tb_exwb_stage;
    import exwb_pkg::*;

    localparam int NCH = 5;
    localparam int TW  = 5;
    localparam int DW  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic [NCH-1:0]  in_valid = '0;
    logic [NCH-1:0]  in_ready;
    logic [NCH*TW-1:0] in_target = '0;
    logic [NCH*DW-1:0] in_data = '0;
    logic [NCH-1:0]  out_valid;
    logic [NCH-1:0]  out_ready = '1;
    logic [NCH*TW-1:0] out_target;
    logic [NCH*DW-1:0] out_data;
`ifdef EXWB_PERF_CNT_EN
    logic [NCH*16-1:0] stall_cnt;
`endif

    exwb_stage #(.NUM_CH(NCH), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_target  (in_target),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_target (out_target),
        .out_data   (out_data)
`ifdef EXWB_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] t;
        logic [DW-1:0] d;
    } exp_t;

    exp_t        sb [NCH][$];
    logic [NCH-1:0] acc = '0;
    int unsigned stall_m [NCH];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a queue of at most two results.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                sb[c].delete();
                stall_m[c] = 0;
            end
            acc = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                logic has, room, take;
                logic [TW-1:0] tg;
                has  = (sb[c].size() != 0);
                room = (sb[c].size() < 2);
                tg   = in_target[c*TW +: TW];
                chk($sformatf("in_ready ch%0d", c), in_ready[c], room);
                chk($sformatf("out_valid ch%0d", c), out_valid[c], has);
                if (has) begin
                    chk($sformatf("out_target ch%0d", c), out_target[c*TW +: TW], sb[c][0].t);
                    chk($sformatf("out_data ch%0d", c), out_data[c*DW +: DW], sb[c][0].d);
                end else begin
                    chk($sformatf("idle target ch%0d", c), out_target[c*TW +: TW], TAG_INVALID);
                end
`ifdef EXWB_PERF_CNT_EN
                chk($sformatf("stall_cnt ch%0d", c), stall_cnt[c*16 +: 16], stall_m[c]);
                if (has && !out_ready[c] && stall_m[c] < 32'hFFFF) stall_m[c]++;
`endif
                take = in_valid[c] && room && !flush && (tg != TAG_INVALID);
                acc[c] = take;
                if (flush) begin
                    sb[c].delete();
                end else begin
                    if (has && out_ready[c]) void'(sb[c].pop_front());
                    if (take) sb[c].push_back('{t: tg, d: in_data[c*DW +: DW]});
                end
            end
        end
    end

    // Hold a result on one channel until the model says it was taken.
    task automatic send(input int c, input logic [TW-1:0] tag);
        int n;
        in_valid[c] = 1'b1;
        in_target[c*TW +: TW] = tag;
        in_data[c*DW +: DW] = $urandom;
        for (n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (acc[c]) break;
        end
        if (n == 50) chk($sformatf("send timeout ch%0d", c), 32'd0, 32'd1);
        in_valid[c] = 1'b0;
    endtask

    initial begin
        #12;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("reset valid ch%0d", c), out_valid[c], 1'b0);
            chk($sformatf("reset ready ch%0d", c), in_ready[c], 1'b1);
            chk($sformatf("reset target ch%0d", c), out_target[c*TW +: TW], 5'h1F);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming on ch0
        send(CH_ALU, 5'd1);
        chk("stream first", out_target[4:0], 5'd1);
        send(CH_ALU, 5'd2);
        chk("stream second", out_target[4:0], 5'd2);
        send(CH_ALU, 5'd3);
        chk("stream third", out_target[4:0], 5'd3);
        chk("stream valid", out_valid[0], 1'b1);
        @(posedge clk);
        #1;

        // Back-pressure on ch3 while ch2 keeps flowing
        out_ready[CH_BRANCH] = 1'b0;
        fork
            begin
                send(CH_BRANCH, 5'd4);
                send(CH_BRANCH, 5'd5);
                chk("bp in_ready full", in_ready[3], 1'b0);
                send(CH_BRANCH, 5'd6);
            end
            begin
                send(CH_JUMP, 5'd12);
                send(CH_JUMP, 5'd13);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready[CH_BRANCH] = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Flush with a full ch1 and a same-cycle push of tag 7
        out_ready[CH_FWD] = 1'b0;
        send(CH_FWD, 5'd20);
        send(CH_FWD, 5'd21);
        flush = 1'b1;
        in_valid[CH_FWD] = 1'b1;
        in_target[1*TW +: TW] = 5'd7;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid[CH_FWD] = 1'b0;
        out_ready[CH_FWD] = 1'b1;
        chk("flush valid", out_valid[1], 1'b0);
        chk("flush ready", in_ready[1], 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Bubble
        in_valid[CH_MEM] = 1'b1;
        in_target[4*TW +: TW] = TAG_INVALID;
        @(posedge clk);
        #1;
        in_valid[CH_MEM] = 1'b0;
        chk("bubble valid", out_valid[4], 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                in_valid[c] = ($urandom_range(0, 1) == 1);
                in_target[c*TW +: TW] = ($urandom_range(0, 7) == 0) ? TAG_INVALID : TW'($urandom_range(0, 30));
                in_data[c*DW +: DW] = $urandom;
                out_ready[c] = ($urandom_range(0, 3) != 0);
            end
            flush = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        flush = 1'b0;
        out_ready = '1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset with ch0 full
        out_ready[CH_ALU] = 1'b0;
        send(CH_ALU, 5'd9);
        send(CH_ALU, 5'd10);
        #2 rst = 1'b0;
        #1;
        chk("async rst valid", out_valid[0], 1'b0);
        chk("async rst target", out_target[4:0], 5'h1F);
        chk("async rst ready", in_ready[0], 1'b1);
        out_ready[CH_ALU] = 1'b1;
        in_valid[CH_ALU] = 1'b1;
        in_target[4:0] = 5'd11;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        in_valid[CH_ALU] = 1'b0;
        chk("post rst push valid", out_valid[0], 1'b1);
        chk("post rst push target", out_target[4:0], 5'd11);
        @(posedge clk);
        #1;

`ifdef EXWB_PERF_CNT_EN
        out_ready[CH_JUMP] = 1'b0;
        send(CH_JUMP, 5'd3);
        repeat (70000) @(posedge clk);
        #1;
        chk("stall saturate", stall_cnt[2*16 +: 16], 16'hFFFF);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("stall after flush", stall_cnt[2*16 +: 16], 16'hFFFF);
        chk("flush clears ch2", out_valid[2], 1'b0);
        out_ready[CH_JUMP] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
